// File: rtl/rc_cmd_uart_rx.sv
// rc_cmd_uart_rx: UART (8N1) command receiver for a two-motor RC vehicle.
//
// Each received byte is decoded into H-bridge pin levels for two motors.
// A watchdog forces both motors off when no recognised command arrives within
// WDOG_CYC cycles.
//
// Optional feature (macro MOTOR_DEADTIME_EN): when a motor's pin pair reverses
// directly (10 <-> 01), that pair drives 00 for DEAD_CYC cycles before taking
// the new value. With the macro undefined there is no dead-time logic.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous reset, active-low
//   rx         in   asynchronous UART line, idle high
//   motor1/2   out  left motor H-bridge inputs A/B
//   motor01/02 out  right motor H-bridge inputs A/B
//   cmd_valid  out  one-cycle pulse when a recognised command is accepted
//   cmd_byte   out  last correctly framed byte, held between frames
//   frame_err  out  one-cycle pulse on a stop-bit error
module rc_cmd_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned WDOG_CYC     = 25000000,
  parameter int unsigned DEAD_CYC     = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       motor1,
  output logic       motor2,
  output logic       motor01,
  output logic       motor02,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       frame_err
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);
  localparam logic [CntW-1:0]  HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0]  BitM1  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [WdogW-1:0] WdogM1 = WdogW'(WDOG_CYC - 1);

  if (CLKS_PER_BIT < 4 || WDOG_CYC < 2 || DEAD_CYC < 1) begin : g_bad_param
    $error("rc_cmd_uart_rx: CLKS_PER_BIT >= 4, WDOG_CYC >= 2, DEAD_CYC >= 1 required");
  end

  // ---------------------------------------------------------------------------
  // rx synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;
  logic w_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_done, w_done_nxt;
  logic            r_frame_err, w_ferr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_done      <= w_done_nxt;
      r_frame_err <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (w_fall) w_state_nxt = StStart;
      end
      StStart: begin
        if (r_cnt == HalfM1) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          // A high line at mid-start is a glitch: drop back silently.
          w_state_nxt = r_rx_sync ? StIdle : StData;
        end
      end
      StData: begin
        if (r_cnt == BitM1) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_nxt = StStop;
          else               w_bit_nxt   = r_bit + 1'b1;
        end
      end
      StStop: begin
        if (r_cnt == BitM1) begin
          w_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // Hold here through a break so it yields a single frame error.
        w_cnt_nxt = '0;
        if (r_rx_sync) w_state_nxt = StIdle;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command decode, order {motor1, motor2, motor01, motor02}
  // ---------------------------------------------------------------------------
  logic       w_hit;
  logic [3:0] w_dec_mot;
  logic       w_cmd_hit;

  always_comb begin
    w_hit     = 1'b1;
    w_dec_mot = 4'b0000;
    case (r_shift)
      8'h46:   w_dec_mot = 4'b1010;  // 'F'
      8'h42:   w_dec_mot = 4'b0101;  // 'B'
      8'h4C:   w_dec_mot = 4'b0110;  // 'L'
      8'h52:   w_dec_mot = 4'b1001;  // 'R'
      8'h53:   w_dec_mot = 4'b0000;  // 'S'
      default: w_hit     = 1'b0;
    endcase
  end

  assign w_cmd_hit = r_done & w_hit;

  logic       r_cmd_valid;
  logic [7:0] r_cmd_byte;
  logic [3:0] r_cmd_mot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= '0;
      r_cmd_mot   <= '0;
    end else begin
      r_cmd_valid <= w_cmd_hit;
      if (r_done) r_cmd_byte <= r_shift;
      if (w_cmd_hit) r_cmd_mot <= w_dec_mot;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: counts from the cmd_valid cycle; saturates at WDOG_CYC-1.
  // ---------------------------------------------------------------------------
  logic [WdogW-1:0] r_wdog_cnt;
  logic             w_wdog_exp;

  assign w_wdog_exp = (r_wdog_cnt == WdogM1);

  always_ff @(posedge clk) begin
    if (!rst_n)           r_wdog_cnt <= '0;
    else if (w_cmd_hit)   r_wdog_cnt <= '0;
    else if (!w_wdog_exp) r_wdog_cnt <= r_wdog_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Motor pin pairs: index 0 = left {motor1, motor2}, 1 = right {motor01, motor02}
  // ---------------------------------------------------------------------------
  logic [1:0] r_pair [2];
  logic [1:0] w_new  [2];

  always_comb begin
    w_new[0] = r_cmd_mot[3:2];
    w_new[1] = r_cmd_mot[1:0];
  end

`ifdef MOTOR_DEADTIME_EN
  localparam int unsigned DeadW = $clog2(DEAD_CYC + 1);
  localparam logic [DeadW-1:0] DeadM1 = DeadW'(DEAD_CYC - 1);

  logic [1:0]       r_dead_act;
  logic [1:0]       r_dead_pend [2];
  logic [DeadW-1:0] r_dead_cnt  [2];
  logic [1:0]       w_rev;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rev[p] = (r_pair[p] == 2'b10 && w_new[p] == 2'b01) ||
                 (r_pair[p] == 2'b01 && w_new[p] == 2'b10);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        r_pair[p]      <= '0;
        r_dead_act[p]  <= 1'b0;
        r_dead_pend[p] <= '0;
        r_dead_cnt[p]  <= '0;
      end else if (w_wdog_exp && !r_cmd_valid) begin
        r_pair[p]     <= '0;
        r_dead_act[p] <= 1'b0;
      end else begin
        if (r_dead_act[p]) begin
          if (r_dead_cnt[p] == DeadM1) begin
            r_pair[p]     <= r_dead_pend[p];
            r_dead_act[p] <= 1'b0;
          end else begin
            r_dead_cnt[p] <= r_dead_cnt[p] + 1'b1;
          end
        end
        if (r_cmd_valid) begin
          if (w_new[p] == 2'b00) begin
            // Stop is never delayed and cancels any pending value.
            r_pair[p]     <= '0;
            r_dead_act[p] <= 1'b0;
          end else if (r_dead_act[p]) begin
            // Replace the pending value; the running count is kept.
            r_dead_pend[p] <= w_new[p];
            if (r_dead_cnt[p] == DeadM1) r_pair[p] <= w_new[p];
          end else if (w_rev[p]) begin
            r_pair[p]      <= '0;
            r_dead_pend[p] <= w_new[p];
            r_dead_cnt[p]  <= '0;
            r_dead_act[p]  <= 1'b1;
          end else begin
            r_pair[p] <= w_new[p];
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n)           r_pair[p] <= '0;
      else if (r_cmd_valid) r_pair[p] <= w_new[p];
      else if (w_wdog_exp)  r_pair[p] <= '0;
    end
  end
`endif

  // Expiry masks the outputs in the very cycle the count reaches its limit.
  assign {motor1, motor2}   = r_pair[0] & {2{~w_wdog_exp}};
  assign {motor01, motor02} = r_pair[1] & {2{~w_wdog_exp}};

  assign cmd_valid = r_cmd_valid;
  assign cmd_byte  = r_cmd_byte;
  assign frame_err = r_frame_err;

endmodule

// File: doc/rc_cmd_uart_rx.md
RC_CMD_UART_RX -- requirements
Module: rc_cmd_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, is the number of clk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 Parameter WDOG_CYC, default 25000000, is the number of cycles without an accepted command before a forced stop (0.5 s).
REQ-003 Parameter DEAD_CYC, default 50000, is the number of break-before-make cycles on a motor reversal (1 ms).
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  synchronous reset, active-low.
REQ-006 rx  input  1  asynchronous UART line, 8N1, idle high.
REQ-007 motor1  output  1  left motor H-bridge input A.
REQ-008 motor2  output  1  left motor H-bridge input B.
REQ-009 motor01  output  1  right motor H-bridge input A.
REQ-010 motor02  output  1  right motor H-bridge input B.
REQ-011 cmd_valid  output  1  one-cycle pulse when a recognised command is accepted.
REQ-012 cmd_byte  output  8  last received byte; held between frames.
REQ-013 frame_err  output  1  one-cycle pulse on a stop-bit error.

Function
REQ-014 rx SHALL pass through a 2-flop synchroniser before use.
REQ-015 The receiver FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE->START on a synchronised falling edge; START samples at CLKS_PER_BIT/2 cycles: low->DATA, high->IDLE (glitch, no pulses).
REQ-017 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample, then enter STOP.
REQ-018 STOP sample high -> cmd_byte updated and byte decoded on the next cycle, then IDLE; low -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL stay until synchronised rx is high, so a held-low break line produces exactly one frame_err.
REQ-020 Decode, as motor1,motor2,motor01,motor02: 'F' 0x46 = 1010; 'B' 0x42 = 0101; 'L' 0x4C = 0110; 'R' 0x52 = 1001; 'S' 0x53 = 0000.
REQ-021 A recognised byte SHALL pulse cmd_valid and restart the watchdog; any other byte SHALL update cmd_byte only, with outputs unchanged and no cmd_valid.
REQ-022 The motor outputs SHALL update on the cycle after cmd_valid (without dead time).
REQ-023 The watchdog counter SHALL increment every cycle; on reaching WDOG_CYC-1 it SHALL force all motor outputs to 0 and hold the count until the next recognised command.
REQ-024 If watchdog expiry and cmd_valid occur in the same cycle, the command SHALL win and the counter SHALL clear.
REQ-025 Invariant: motor1&motor2 and motor01&motor02 SHALL never be 1 simultaneously.

Reset
REQ-026 With rst_n low at a clk edge, all motor outputs, cmd_valid, frame_err, cmd_byte and the watchdog and dead-time counters SHALL be cleared, and the FSM SHALL enter IDLE.
REQ-027 A reset asserted mid-frame SHALL discard the partial byte and cause no cmd_valid or frame_err.

Configuration
REQ-028 Macro MOTOR_DEADTIME_EN defined: when a motor's pin pair changes directly from 10 to 01 or 01 to 10, that pair SHALL drive 00 for DEAD_CYC cycles and then the new value.
REQ-029 Dead time SHALL apply independently per motor, and a new command during dead time SHALL replace the pending value without restarting the count.
REQ-030 A watchdog stop or an 'S' command SHALL apply 00 immediately, cancelling any pending dead time.
REQ-031 Macro MOTOR_DEADTIME_EN undefined: there SHALL be no dead-time logic, and every output change SHALL occur per REQ-022.

Verification (CLKS_PER_BIT=16, WDOG_CYC=2000, DEAD_CYC=8)
REQ-032 Send 0x46 -> cmd_valid pulse, cmd_byte=0x46, outputs 1010 one cycle later.
REQ-033 Send 0x46, then 0x41 -> cmd_byte=0x41, no cmd_valid, outputs remain 1010.
REQ-034 Send 0x4C, then idle for 2000 cycles -> outputs 0000 at cycle 1999 after cmd_valid; send 0x42 -> 0101.
REQ-035 Send a frame with stop bit 0, holding rx low for 100 bits -> exactly one frame_err, then a 0x53 frame decodes normally.
REQ-036 MOTOR_DEADTIME_EN defined, 'F' then 'B' -> outputs 0000 for 8 cycles, then 0101; macro undefined -> 0101 the cycle after cmd_valid.
REQ-037 Assert rst_n low during DATA bit 4 of 0x52 -> all outputs 0, no pulses; the next full 0x52 frame gives 1001.
